// File: rtl/pea_pkg.sv
// Shared PE-array types and constants: operand source select, collector FSM
// states and default sizing for the operand collector.
package pea_pkg;

    localparam int N_BITS         = 32;
    localparam int OPC_FIFO_DEPTH = 2;

    // Encoding 3 is unused and decodes as zero.
    typedef enum logic [1:0] {
        OP_SRC_STREAM = 2'd0,
        OP_SRC_CONST  = 2'd1,
        OP_SRC_ZERO   = 2'd2
    } op_src_t;

    typedef enum logic {
        OPC_IDLE = 1'b0,
        OPC_BUSY = 1'b1
    } opc_state_t;

    function automatic logic is_stream(input op_src_t sel);
        return sel == OP_SRC_STREAM;
    endfunction

endpackage

// File: rtl/pe_operand_collector_if.sv
// Operand-collector bundle: A/B streams, operand select/config, FU loop-back
// and issue outputs. Signal suffixes are from the collector's point of view.
interface pe_operand_collector_if
    import pea_pkg::*;
#(
    parameter int N_BITS = pea_pkg::N_BITS
);
    logic              clear_i;
    op_src_t           a_sel_i;
    op_src_t           b_sel_i;
    logic [N_BITS-1:0] const_i;
    logic [N_BITS-1:0] a_i;
    logic [N_BITS-1:0] b_i;
    logic              a_valid_i;
    logic              b_valid_i;
    logic              a_ready_o;
    logic              b_ready_o;
    logic              acc_loopback_i;
    logic [N_BITS-1:0] fu_res_i;
    logic              long_op_i;
    logic              fu_valid_i;
    logic [N_BITS-1:0] a_o;
    logic [N_BITS-1:0] b_o;
    logic              ops_valid_o;
    logic              inflight_o;

    modport slave (
        input  clear_i, a_sel_i, b_sel_i, const_i, a_i, b_i, a_valid_i, b_valid_i,
               acc_loopback_i, fu_res_i, long_op_i, fu_valid_i,
        output a_ready_o, b_ready_o, a_o, b_o, ops_valid_o, inflight_o
    );

    modport master (
        output clear_i, a_sel_i, b_sel_i, const_i, a_i, b_i, a_valid_i, b_valid_i,
               acc_loopback_i, fu_res_i, long_op_i, fu_valid_i,
        input  a_ready_o, b_ready_o, a_o, b_o, ops_valid_o, inflight_o
    );

endinterface

// File: rtl/opc_fifo.sv
// Small operand buffer: registered storage, combinational head, ready derived
// from count only so there is no valid-to-ready path.
module opc_fifo #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [N_BITS-1:0]          data_i,
    input  logic                       pop_i,
    output logic [N_BITS-1:0]          head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && (count_q != '0) && !clear_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pe_operand_collector.sv
// Collects an A/B operand pair for the FU, with constant/zero selection,
// accumulator loop-back on A and a busy flag that holds issue during long ops.
module pe_operand_collector
    import pea_pkg::*;
#(
    parameter int N_BITS     = pea_pkg::N_BITS,
    parameter int FIFO_DEPTH = OPC_FIFO_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    pe_operand_collector_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [N_BITS-1:0] din    [2];
    logic [N_BITS-1:0] head   [2];
    logic [N_BITS-1:0] opnd   [2];
    logic [CW-1:0]     cnt    [2];
    op_src_t           sel    [2];
    logic [1:0]        push_req;
    logic [1:0]        pop;
    logic [1:0]        full;
    logic [1:0]        avail;
    logic              issue;
    opc_state_t        state_q;
    logic [N_BITS-1:0] acc_q;

    assign din[0]   = bus.a_i;
    assign din[1]   = bus.b_i;
    assign sel[0]   = bus.a_sel_i;
    assign sel[1]   = bus.b_sel_i;
    assign push_req = {bus.b_valid_i, bus.a_valid_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            opc_fifo #(
                .N_BITS (N_BITS),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .clear_i (bus.clear_i),
                .push_i  (push_req[gi]),
                .data_i  (din[gi]),
                .pop_i   (pop[gi]),
                .head_o  (head[gi]),
                .count_o (cnt[gi]),
                .full_o  (full[gi])
            );

            // An empty stream presents zero rather than stale storage.
            assign opnd[gi]  = is_stream(sel[gi]) ? ((cnt[gi] != '0) ? head[gi] : '0)
                             : (sel[gi] == OP_SRC_CONST) ? bus.const_i : '0;
            assign avail[gi] = !is_stream(sel[gi]) || (cnt[gi] != '0);
        end
    endgenerate

    assign issue = (avail[0] || bus.acc_loopback_i) && avail[1]
                   && (state_q == OPC_IDLE) && !bus.clear_i;

    // Loop-back replaces A entirely, so its buffer is left untouched.
    assign pop[0] = issue && is_stream(sel[0]) && !bus.acc_loopback_i;
    assign pop[1] = issue && is_stream(sel[1]);

    assign bus.a_o         = bus.acc_loopback_i ? acc_q : opnd[0];
    assign bus.b_o         = opnd[1];
    assign bus.a_ready_o   = !full[0];
    assign bus.b_ready_o   = !full[1];
    assign bus.ops_valid_o = issue;
    assign bus.inflight_o  = (state_q == OPC_BUSY);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= OPC_IDLE;
            acc_q   <= '0;
        end else if (bus.clear_i) begin
            state_q <= OPC_IDLE;
            acc_q   <= '0;
        end else begin
            if (issue) acc_q <= bus.fu_res_i;
            case (state_q)
                OPC_IDLE: if (issue && bus.long_op_i) state_q <= OPC_BUSY;
                OPC_BUSY: if (bus.fu_valid_i)         state_q <= OPC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_operand_collector.sv
// Directed bench for pe_operand_collector: stimulus queues expected operand
// pairs and level probes, a negedge monitor compares against the DUT.
module tb_pe_operand_collector;
    import pea_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } probe_t;

    localparam int K_A_READY  = 0;
    localparam int K_B_READY  = 1;
    localparam int K_OPS_VLD  = 2;
    localparam int K_INFLIGHT = 3;
    localparam int K_A_O      = 4;
    localparam int K_B_O      = 5;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    pair_t  sb_q [$];
    probe_t probe_q [$];
    int     checks = 0;
    int     errors = 0;
    bit     done   = 1'b0;

    pe_operand_collector_if #(.N_BITS(32)) bus ();

    pe_operand_collector #(
        .N_BITS     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // The FU model is an adder, which makes loop-back a running sum.
    assign bus.fu_res_i = bus.a_o + bus.b_o;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [31:0] a, input logic [31:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        sb_q.push_back(p);
    endtask

    task automatic probe(input string name, input int kind, input logic [31:0] exp);
        probe_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        probe_q.push_back(e);
    endtask

    always @(negedge clk) begin
        probe_t      e;
        pair_t       p;
        logic [31:0] act;
        act = '0;
        while (probe_q.size() != 0) begin
            e = probe_q.pop_front();
            case (e.kind)
                K_A_READY:  act = {31'd0, bus.a_ready_o};
                K_B_READY:  act = {31'd0, bus.b_ready_o};
                K_OPS_VLD:  act = {31'd0, bus.ops_valid_o};
                K_INFLIGHT: act = {31'd0, bus.inflight_o};
                K_A_O:      act = bus.a_o;
                default:    act = bus.b_o;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0d required %0d", e.name, act, e.exp);
            end
        end
        if (bus.ops_valid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got a=%0d b=%0d required no issue", bus.a_o, bus.b_o);
            end else begin
                p = sb_q.pop_front();
                if (bus.a_o !== p.a || bus.b_o !== p.b) begin
                    errors++;
                    $display("FAIL issue_pair: got a=%0d b=%0d required a=%0d b=%0d",
                             bus.a_o, bus.b_o, p.a, p.b);
                end else begin
                    $display("issue a=%0d b=%0d ok", bus.a_o, bus.b_o);
                end
            end
        end else if (bus.ops_valid_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL ops_valid_known: got %b required 0 or 1", bus.ops_valid_o);
        end
        if (done) begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL missing_issues: got %0d pending required 0", sb_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        bus.clear_i        = 1'b0;
        bus.a_sel_i        = OP_SRC_STREAM;
        bus.b_sel_i        = OP_SRC_STREAM;
        bus.const_i        = '0;
        bus.a_i            = '0;
        bus.b_i            = '0;
        bus.a_valid_i      = 1'b0;
        bus.b_valid_i      = 1'b0;
        bus.acc_loopback_i = 1'b0;
        bus.long_op_i      = 1'b0;
        bus.fu_valid_i     = 1'b0;
        tick();
        tick();

        // Reset values
        probe("rst_a_ready", K_A_READY, 1);
        probe("rst_b_ready", K_B_READY, 1);
        probe("rst_ops_valid", K_OPS_VLD, 0);
        probe("rst_inflight", K_INFLIGHT, 0);
        probe("rst_a_o", K_A_O, 0);
        probe("rst_b_o", K_B_O, 0);
        tick();
        rst_n = 1'b1;

        // First pair, one cycle after the push
        bus.a_valid_i = 1; bus.a_i = 5; bus.b_valid_i = 1; bus.b_i = 7;
        probe("t1_ops_valid_same_cycle", K_OPS_VLD, 0);
        tick();
        bus.a_valid_i = 0; bus.b_valid_i = 0;
        expect_pair(5, 7);
        probe("t1_a_ready", K_A_READY, 1);
        probe("t1_b_ready", K_B_READY, 1);
        tick();

        // Backpressure on A with ordered drain
        bus.a_valid_i = 1; bus.a_i = 10; tick();
        bus.a_i = 11; probe("bp_ready_one", K_A_READY, 1); tick();
        bus.a_i = 12; probe("bp_ready_full", K_A_READY, 0); tick();
        bus.b_valid_i = 1; bus.b_i = 1; probe("bp_ready_held", K_A_READY, 0); tick();
        bus.b_valid_i = 0; expect_pair(10, 1); probe("bp_ready_pop_cycle", K_A_READY, 0); tick();
        probe("bp_ready_after_pop", K_A_READY, 1); tick();
        bus.a_valid_i = 0; bus.b_valid_i = 1; bus.b_i = 2; tick();
        bus.b_i = 3; expect_pair(11, 2); tick();
        bus.b_valid_i = 0; expect_pair(12, 3); tick();

        // Constant B, back-to-back A stream
        bus.b_sel_i = OP_SRC_CONST; bus.const_i = 3;
        bus.a_valid_i = 1; bus.a_i = 1; tick();
        bus.a_i = 2; expect_pair(1, 3); tick();
        bus.a_i = 3; expect_pair(2, 3); tick();
        bus.a_valid_i = 0; expect_pair(3, 3); tick();
        bus.b_sel_i = OP_SRC_STREAM; tick();

        // Accumulate loop-back; A=9 must survive the loop-back issues
        bus.a_valid_i = 1; bus.a_i = 4; bus.b_valid_i = 1; bus.b_i = 1; tick();
        bus.a_valid_i = 0; bus.b_i = 2; expect_pair(4, 1); tick();
        bus.acc_loopback_i = 1; bus.a_valid_i = 1; bus.a_i = 9; bus.b_i = 3;
        expect_pair(5, 2); tick();
        bus.a_valid_i = 0; bus.b_i = 0; expect_pair(7, 3); tick();
        bus.b_valid_i = 0; expect_pair(10, 0); tick();
        bus.acc_loopback_i = 0; bus.b_valid_i = 1; bus.b_i = 1; tick();
        bus.b_valid_i = 0; expect_pair(9, 1); tick();

        // Long op holds issue until fu_valid_i
        bus.a_valid_i = 1; bus.a_i = 100; bus.b_valid_i = 1; bus.b_i = 200; tick();
        bus.long_op_i = 1; bus.a_i = 101; bus.b_i = 201; expect_pair(100, 200); tick();
        bus.long_op_i = 0; bus.a_i = 102; bus.b_i = 202;
        probe("lo_inflight_set", K_INFLIGHT, 1); tick();
        bus.a_valid_i = 0; bus.b_valid_i = 0;
        probe("lo_a_full", K_A_READY, 0);
        probe("lo_b_full", K_B_READY, 0);
        for (int i = 0; i < 34; i++) begin
            probe("lo_inflight_hold", K_INFLIGHT, 1);
            probe("lo_blocked", K_OPS_VLD, 0);
            tick();
        end
        bus.fu_valid_i = 1; probe("lo_inflight_at_fu_valid", K_INFLIGHT, 1); tick();
        bus.fu_valid_i = 0; probe("lo_inflight_clr", K_INFLIGHT, 0);
        expect_pair(101, 201); tick();
        expect_pair(102, 202); tick();

        // Clear with full buffers and a long op outstanding
        bus.a_valid_i = 1; bus.a_i = 50; bus.b_valid_i = 1; bus.b_i = 60; tick();
        bus.long_op_i = 1; bus.a_i = 51; bus.b_i = 61; expect_pair(50, 60); tick();
        bus.long_op_i = 0; bus.a_i = 52; bus.b_i = 62; tick();
        bus.clear_i = 1; bus.a_i = 99; bus.b_i = 98;
        probe("clr_inflight_before", K_INFLIGHT, 1);
        probe("clr_ops_valid", K_OPS_VLD, 0); tick();
        bus.clear_i = 0; bus.a_valid_i = 0; bus.b_i = 5;
        probe("clr_a_ready", K_A_READY, 1);
        probe("clr_b_ready", K_B_READY, 1);
        probe("clr_inflight", K_INFLIGHT, 0);
        probe("clr_ops_valid_after", K_OPS_VLD, 0);
        probe("clr_a_o", K_A_O, 0);
        probe("clr_b_o", K_B_O, 0); tick();
        bus.b_valid_i = 0; bus.acc_loopback_i = 1; expect_pair(0, 5); tick();
        bus.acc_loopback_i = 0; bus.clear_i = 1;
        bus.a_valid_i = 1; bus.a_i = 77; bus.b_valid_i = 1; bus.b_i = 6; tick();
        bus.clear_i = 0; bus.a_valid_i = 0; tick();
        bus.b_valid_i = 0; bus.a_valid_i = 1; bus.a_i = 7; tick();
        bus.a_valid_i = 0; expect_pair(7, 6); tick();

        // Zero / constant / reserved-encoding selects
        bus.a_sel_i = OP_SRC_ZERO; bus.b_sel_i = OP_SRC_CONST; bus.const_i = 3;
        expect_pair(0, 3); tick();
        bus.a_sel_i = op_src_t'(2'd3); expect_pair(0, 3); tick();
        bus.a_sel_i = OP_SRC_CONST; bus.b_sel_i = OP_SRC_ZERO; bus.const_i = 9;
        expect_pair(9, 0); tick();
        bus.a_sel_i = OP_SRC_STREAM; bus.b_sel_i = OP_SRC_STREAM;
        probe("idle_no_issue", K_OPS_VLD, 0); tick();

        done = 1'b1;
        tick();
        tick();
    end

endmodule
